// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch front end. Owns the fetch address, issues one word read at
// a time to instruction memory over a req/ack handshake, buffers returned
// words together with their PCs in a small FIFO, and presents the FIFO head to
// decode over a valid/ready handshake. A redirect flushes the FIFO and
// restarts fetch at a new word-aligned address. A request that is still
// outstanding when a redirect arrives is completed and its data discarded.
//
// Optional feature macro: IFETCH_BYPASS_EN
//   When defined, an ack that arrives while the FIFO is empty is forwarded
//   combinationally to decode in the same cycle. If decode takes it that
//   cycle, the word is not pushed.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous reset, active-high
//   imem_req     read request to instruction memory
//   imem_addr    word-aligned read address (stable while imem_req is held)
//   imem_ack     memory response valid, data on imem_data this cycle
//   imem_data    instruction word from memory
//   instr_valid  FIFO head valid to decode
//   instr_ready  decode accepts the head this cycle
//   instr        head instruction (0 when nothing is valid)
//   instr_pc     PC of head instruction (0 when nothing is valid)
//   redirect     flush and restart fetch
//   redirect_pc  new fetch address (low two bits ignored)
//   fetch_pc     current fetch address register
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  fetch_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_FULL  = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  // Control state (reset)
  state_e             state_q,     state_d;
  logic [ADDR_W-1:0]  fetch_pc_q,  fetch_pc_d;
  logic [ADDR_W-1:0]  drop_addr_q, drop_addr_d;
  logic [CNT_W-1:0]   count_q,     count_d;
  logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
  logic               en_q;

  // FIFO storage (data path, not reset)
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

  logic               fifo_empty;
  logic               room;
  logic               req;
  logic               acked;
  logic               push;
  logic               pop;
  logic               bypass;
  logic [ADDR_W-1:0]  redirect_aligned;

  assign fifo_empty       = (count_q == '0);
  assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

  // count_q never includes the outstanding request, but the request stays
  // raised until its ack and count can only fall meanwhile, so checking
  // count < DEPTH at issue time already reserves the slot the ack will fill.
  assign room  = (count_q < DEPTH_C);

  // en_q keeps the request low in the first cycle after reset so a reset
  // cycle never starts a transaction and a late ack to a killed request
  // lands on imem_req=0.
  assign req   = en_q && (((state_q == ST_FETCH) && room) || (state_q == ST_DROP));
  assign acked = req && imem_ack;

`ifdef IFETCH_BYPASS_EN
  assign bypass = (state_q == ST_FETCH) && acked && fifo_empty && !redirect;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = !fifo_empty && instr_ready;
  assign push = (state_q == ST_FETCH) && acked && !redirect && !(bypass && instr_ready);

  assign imem_req    = req;
  assign imem_addr   = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;
  assign fetch_pc    = fetch_pc_q;
  assign instr_valid = !fifo_empty || bypass;

  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (!fifo_empty) begin
      instr    = instr_mem_q[rd_ptr_q];
      instr_pc = pc_mem_q[rd_ptr_q];
    end else if (bypass) begin
      instr    = imem_data;
      instr_pc = fetch_pc_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    if (redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_aligned;
      if (req && !imem_ack) begin
        // Keep presenting the old address until the memory answers it.
        state_d     = ST_DROP;
        drop_addr_d = imem_addr;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      unique case (state_q)
        ST_FETCH: begin
          if (acked) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
          if (count_d == DEPTH_C) state_d = ST_FULL;
        end
        ST_FULL: begin
          if (pop) state_d = ST_FETCH;
        end
        ST_DROP: begin
          if (acked) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      en_q        <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_data;
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;

  int tests = 0;
  int fails = 0;

  instr_fetch_unit #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_data = '0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_data = '0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req cyc%0d got %0b want 0", c, imem_req); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid cyc%0d got %0b want 0", c, instr_valid); end
    end
    tests++; if (fetch_pc !== 32'h0) begin fails++; $display("FAIL reset_fetch_pc got %h want 00000000", fetch_pc); end
    tests++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin fails++; $display("FAIL reset_outputs got %h/%h want 0/0", instr, instr_pc); end
    rst = 1'b0;
    tick();
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL start_req got %0b want 1", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL start_addr got %h want 00000000", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    do_reset();
    instr_ready = 1'b1;
    imem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      imem_data = 32'hA000_0000 + 32'(4 * i);
      #1;
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin fails++; $display("FAIL stream_addr%0d got %0b/%h want 1/%h", i, imem_req, imem_addr, 32'(4 * i)); end
`ifdef IFETCH_BYPASS_EN
      exp = 32'(4 * i);
      tests++; if (instr_valid !== 1'b1 || instr_pc !== exp || instr !== 32'hA000_0000 + exp) begin fails++; $display("FAIL stream_byp%0d got %0b %h %h want 1 %h %h", i, instr_valid, instr_pc, instr, exp, 32'hA000_0000 + exp); end
`else
      if (i > 0) begin
        exp = 32'(4 * (i - 1));
        tests++; if (instr_valid !== 1'b1 || instr_pc !== exp || instr !== 32'hA000_0000 + exp) begin fails++; $display("FAIL stream_out%0d got %0b %h %h want 1 %h %h", i, instr_valid, instr_pc, instr, exp, 32'hA000_0000 + exp); end
      end else begin
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL stream_lat0 got %0b want 0", instr_valid); end
      end
`endif
      tick();
    end
    imem_ack = 1'b0;
    #1;
`ifdef IFETCH_BYPASS_EN
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL stream_tail got %0b want 0", instr_valid); end
`else
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h14 || instr !== 32'hA000_0014) begin fails++; $display("FAIL stream_tail got %0b %h %h want 1 00000014 a0000014", instr_valid, instr_pc, instr); end
`endif
    tests++; if (fetch_pc !== 32'h18) begin fails++; $display("FAIL stream_fetch_pc got %h want 00000018", fetch_pc); end
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    imem_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      imem_data = 32'hA000_0000 + 32'(4 * c);
      #1;
      if (c < 4) begin
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * c)) begin fails++; $display("FAIL bp_fill%0d got %0b/%h want 1/%h", c, imem_req, imem_addr, 32'(4 * c)); end
      end else begin
        tests++; if (imem_req !== 1'b0 || fetch_pc !== 32'h10) begin fails++; $display("FAIL bp_full%0d got %0b/%h want 0/00000010", c, imem_req, fetch_pc); end
      end
      tick();
    end
    imem_ack = 1'b0;
    instr_ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      #1;
      tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * d) || instr !== 32'hA000_0000 + 32'(4 * d)) begin fails++; $display("FAIL bp_drain%0d got %0b %h %h want 1 %h %h", d, instr_valid, instr_pc, instr, 32'(4 * d), 32'hA000_0000 + 32'(4 * d)); end
      if (d == 1) begin
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin fails++; $display("FAIL bp_resume got %0b/%h want 1/00000010", imem_req, imem_addr); end
      end
      tick();
    end
    tests++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin fails++; $display("FAIL bp_empty got %0b %0b %h want 0 1 00000010", instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    instr_ready = 1'b0;
    imem_ack = 1'b1;
    imem_data = 32'hA000_0000; tick();
    imem_data = 32'hA000_0004; tick();
    imem_ack = 1'b0;
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin fails++; $display("FAIL rd_hold got %0b/%h want 1/00000008", imem_req, imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h0000_00C8;
    #1;
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin fails++; $display("FAIL rd_before got %0b %h want 1 00000000", instr_valid, instr_pc); end
    tick();
    redirect = 1'b0;
    #1;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rd_flush got %0b want 0", instr_valid); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || fetch_pc !== 32'hC8) begin fails++; $display("FAIL rd_drop got %0b %h %h want 1 00000008 000000c8", imem_req, imem_addr, fetch_pc); end
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin fails++; $display("FAIL rd_drop2 got %0b/%h want 1/00000008", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
    #1;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rd_stale_out got %0b want 0", instr_valid); end
    tick();
    imem_ack = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hC8 || instr_valid !== 1'b0) begin fails++; $display("FAIL rd_newreq got %0b %h %0b want 1 000000c8 0", imem_req, imem_addr, instr_valid); end
    imem_ack = 1'b1; imem_data = 32'hA000_00C8;
    tick();
    imem_ack = 1'b0;
    #1;
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC8 || instr !== 32'hA000_00C8) begin fails++; $display("FAIL rd_newdata got %0b %h %h want 1 000000c8 a00000c8", instr_valid, instr_pc, instr); end
    tests++; if (fetch_pc !== 32'hCC) begin fails++; $display("FAIL rd_fetch_pc got %h want 000000cc", fetch_pc); end
  endtask

  task automatic test_wrap();
    do_reset();
    instr_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    imem_ack = 1'b1; imem_data = 32'h0BAD_0BAD;
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    #1;
    tests++; if (fetch_pc !== 32'hFFFF_FFFC || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_align got %h %0b %h want fffffffc 1 fffffffc", fetch_pc, imem_req, imem_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL wrap_discard got %0b want 0", instr_valid); end
    imem_ack = 1'b1; imem_data = 32'h1111_1111;
    tick();
    imem_ack = 1'b0;
    #1;
    tests++; if (fetch_pc !== 32'h0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin fails++; $display("FAIL wrap_next got %h %h %0b want 0 0 1", fetch_pc, imem_addr, imem_req); end
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr !== 32'h1111_1111) begin fails++; $display("FAIL wrap_data got %0b %h %h want 1 fffffffc 11111111", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    instr_ready = 1'b0;
    imem_ack = 1'b1; imem_data = 32'hA000_0000;
    tick();
    imem_data = 32'hA000_0004; instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    #1;
    tests++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin fails++; $display("FAIL sim_flush got %0b %h %h want 0 0 0", instr_valid, instr, instr_pc); end
    tests++; if (fetch_pc !== 32'h40 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin fails++; $display("FAIL sim_target got %h %0b %h want 00000040 1 00000040", fetch_pc, imem_req, imem_addr); end
    imem_ack = 1'b1; imem_data = 32'h5555_0040;
    #1;
`ifdef IFETCH_BYPASS_EN
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h5555_0040) begin fails++; $display("FAIL sim_bypass got %0b %h %h want 1 00000040 55550040", instr_valid, instr_pc, instr); end
`else
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL sim_nobypass got %0b want 0", instr_valid); end
`endif
    tick();
    imem_ack = 1'b0;
    #1;
`ifdef IFETCH_BYPASS_EN
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL sim_consumed got %0b want 0", instr_valid); end
`else
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h5555_0040) begin fails++; $display("FAIL sim_latency got %0b %h %h want 1 00000040 55550040", instr_valid, instr_pc, instr); end
`endif
    tick();
    tests++; if (instr_valid !== 1'b0 || fetch_pc !== 32'h44) begin fails++; $display("FAIL sim_empty got %0b %h want 0 00000044", instr_valid, fetch_pc); end
    imem_ack = 1'b1; imem_data = 32'h7777_0044;
    redirect = 1'b1; redirect_pc = 32'h0000_0080;
    #1;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL sim_redir_suppress got %0b want 0", instr_valid); end
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    #1;
    tests++; if (instr_valid !== 1'b0 || fetch_pc !== 32'h80 || imem_addr !== 32'h80) begin fails++; $display("FAIL sim_redir_after got %0b %h %h want 0 00000080 00000080", instr_valid, fetch_pc, imem_addr); end
  endtask

  task automatic test_reset_midreq();
    do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_ack = 1'b1; imem_data = 32'hFACE_FACE;
    #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL midrst_req got %0b want 0", imem_req); end
    tick();
    imem_ack = 1'b0;
    #1;
    tests++; if (instr_valid !== 1'b0 || fetch_pc !== 32'h0 || imem_req !== 1'b1) begin fails++; $display("FAIL midrst_late_ack got %0b %h %0b want 0 0 1", instr_valid, fetch_pc, imem_req); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_wrap();
    test_simultaneous();
    test_reset_midreq();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
